// File: rtl/sr_fifo.sv
// sr_fifo: CPU PUSH/POP queue with first-word-fall-through read data,
// occupancy/status flags, sticky error flags and a high-watermark counter.

// One storage word. It has no reset because only entries between rd and wr
// pointers are ever observed, and dout is forced to zero when the queue is empty.
module sr_fifo_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture the write data when this entry is the write target.
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end

endmodule

module sr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic [AW:0]      hiwater,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wrPtr, rdPtr;
  logic [AW:0]                 cntQ, cntNxt, hiQ;
  logic                        emptyQ, fullQ, ovfQ, udfQ;
  logic                        doPush, doPop;

  // A pop needs data; a push needs room, or a slot freed by a same-cycle pop.
  // Both decisions use only the pre-edge state, so full+push+pop is lossless.
  assign doPop  = pop & (cntQ != '0);
  assign doPush = push & ((cntQ != CntFull) | doPop);

  // Next occupancy: simultaneous accepted push and pop cancel out.
  always_comb begin
    cntNxt = cntQ;
    case ({doPush, doPop})
      2'b10:   cntNxt = cntQ + 1'b1;
      2'b01:   cntNxt = cntQ - 1'b1;
      default: cntNxt = cntQ;
    endcase
  end

  // Storage array: one entry instance per slot, written at wrPtr.
  for (genvar i = 0; i < DEPTH; i++) begin : gEnt
    sr_fifo_entry #(.WIDTH(WIDTH)) uEnt (
      .clk (clk),
      .we  (doPush && (wrPtr == AW'(i))),
      .d   (din),
      .q   (mem[i])
    );
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Occupancy plus registered empty/full so status outputs are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntQ   <= '0;
      emptyQ <= 1'b1;
      fullQ  <= 1'b0;
    end else begin
      cntQ   <= cntNxt;
      emptyQ <= (cntNxt == '0);
      fullQ  <= (cntNxt == CntFull);
    end
  end

  // High watermark tracks the peak occupancy; a clear restarts it from the
  // occupancy being entered this cycle rather than from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiQ <= '0;
    end else if (clr_err) begin
      hiQ <= cntNxt;
    end else if (cntNxt > hiQ) begin
      hiQ <= cntNxt;
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfQ <= 1'b0;
      udfQ <= 1'b0;
    end else begin
      ovfQ <= (ovfQ & ~clr_err) | (push & ~doPush);
      udfQ <= (udfQ & ~clr_err) | (pop & ~doPop);
    end
  end

  // Head word falls through combinationally; zero while empty so stale or
  // uninitialised storage never reaches the core.
  assign dout      = emptyQ ? '0 : mem[rdPtr];
  assign empty     = emptyQ;
  assign full      = fullQ;
  assign count     = cntQ;
  assign hiwater   = hiQ;
  assign overflow  = ovfQ;
  assign underflow = udfQ;

endmodule

// File: tb/tb_sr_fifo.sv
// Directed bench for sr_fifo (WIDTH=32, DEPTH=8). Inputs change on the
// falling edge; outputs are checked on the falling edge before inputs move.
module tb_sr_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] din = '0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] dout;
  logic        empty, full, overflow, underflow;
  logic [3:0]  count, hiwater;

  int total = 0;
  int bad   = 0;

  sr_fifo #(.WIDTH(32), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .push      (push),
    .pop       (pop),
    .clr_err   (clr_err),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .hiwater   (hiwater),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // ---- reset with random traffic ----
    #1 rst_n = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_hiw", hiwater, 0);
    repeat (4) begin
      cyc();
      din = $urandom; push = 1'($urandom); pop = 1'($urandom);
    end
    cyc();
    chk("rsthold_empty", empty, 1);
    chk("rsthold_count", count, 0);
    chk("rsthold_dout", dout, 0);
    chk("rsthold_flags", {overflow, underflow}, 0);
    chk("rsthold_hiw", hiwater, 0);

    // ---- first push after release ----
    rst_n = 1'b1; push = 1'b1; pop = 1'b0; din = 32'hA5A5A5A5;
    cyc();
    push = 1'b0;
    chk("first_dout", dout, 32'hA5A5A5A5);
    chk("first_count", count, 1);
    chk("first_empty", empty, 0);
    pop = 1'b1;
    chk("pop_same_cycle", dout, 32'hA5A5A5A5);
    cyc();
    pop = 1'b0;
    chk("drain1_empty", empty, 1);
    chk("drain1_dout", dout, 0);
    chk("drain1_hiw", hiwater, 1);

    // ---- fill 0x10..0x17 ----
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; din = 32'h10 + i;
      cyc();
    end
    push = 1'b0;
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("fill_hiw", hiwater, 8);
    chk("fill_head", dout, 32'h10);

    // ---- pop 3 ----
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      chk($sformatf("pop3_%0d", i), dout, 32'h10 + i);
      cyc();
    end
    pop = 1'b0;
    chk("pop3_count", count, 5);
    chk("pop3_full", full, 0);

    // ---- push 0x18..0x1A (wraps) ----
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; din = 32'h18 + i;
      cyc();
    end
    push = 1'b0;
    chk("wrap_full", full, 1);
    chk("wrap_count", count, 8);

    // ---- overflow at full ----
    push = 1'b1; din = 32'hDEAD;
    cyc();
    push = 1'b0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 8);
    chk("ovf_head", dout, 32'h13);

    // ---- clear with no traffic ----
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_hiw", hiwater, 8);

    // ---- push+pop at full ----
    push = 1'b1; pop = 1'b1; din = 32'hBEEF;
    chk("pp_full_head", dout, 32'h13);
    cyc();
    push = 1'b0; pop = 1'b0;
    chk("pp_full_count", count, 8);
    chk("pp_full_ovf", overflow, 0);
    chk("pp_full_full", full, 1);

    // ---- drain 8: 0x14..0x1A then 0xBEEF ----
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      chk($sformatf("drain_%0d", i), dout, (i < 7) ? (32'h14 + i) : 32'hBEEF);
      cyc();
    end
    pop = 1'b0;
    chk("drain_empty", empty, 1);
    chk("drain_dout", dout, 0);
    chk("drain_udf", underflow, 0);

    // ---- underflow ----
    pop = 1'b1;
    chk("udf_dout_during", dout, 0);
    cyc();
    pop = 1'b0;
    chk("udf_flag", underflow, 1);
    chk("udf_count", count, 0);

    // ---- push+pop on empty ----
    push = 1'b1; pop = 1'b1; din = 32'h55;
    chk("pp_empty_nobypass", dout, 0);
    cyc();
    push = 1'b0; pop = 1'b0;
    chk("pp_empty_count", count, 1);
    chk("pp_empty_dout", dout, 32'h55);
    chk("pp_empty_udf", underflow, 1);

    // ---- clear reloads hiwater with count ----
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("clr2_udf", underflow, 0);
    chk("clr2_hiw", hiwater, 1);

    // ---- clear coinciding with an overflowing push ----
    for (int i = 0; i < 7; i++) begin
      push = 1'b1; din = 32'h60 + i;
      cyc();
    end
    chk("refill_full", full, 1);
    chk("refill_hiw", hiwater, 8);
    din = 32'h99; clr_err = 1'b1;
    cyc();
    push = 1'b0; clr_err = 1'b0;
    chk("clr_vs_ovf", overflow, 1);
    chk("clr_vs_ovf_hiw", hiwater, 8);
    chk("clr_vs_ovf_head", dout, 32'h55);

    // ---- async reset mid-traffic at count 5 ----
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      cyc();
    end
    pop = 1'b0;
    chk("pre_arst_count", count, 5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_dout", dout, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_hiw", hiwater, 0);
    cyc();
    rst_n = 1'b1; push = 1'b1; din = 32'h77;
    cyc();
    push = 1'b0;
    chk("post_arst_dout", dout, 32'h77);
    chk("post_arst_count", count, 1);
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    chk("post_arst_empty", empty, 1);
    chk("post_arst_dout0", dout, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
